// File: rtl/sel_tab_sat.sv
// Tournament-predictor chooser table: DEPTH saturating counters selecting P0/P1,
// trained from predictor outcomes, with registered write-first reads and an init sweep.
module sel_tab_sat #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned INIT_VAL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    output logic              busy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic              rd_sel,
    input  logic              up_en,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic              up_p0_ok,
    input  logic              up_p1_ok
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(INIT_VAL);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  ptr, ptr_next;
    logic [CNT_W-1:0]   mem [DEPTH];

    logic [CNT_W-1:0]   up_cur, up_new;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [CNT_W-1:0]   wr_data;
    logic               rd_fire;
    logic [CNT_W-1:0]   rd_data;

    // Saturating counter step toward whichever predictor alone was right
    always_comb begin
        up_cur = mem[up_addr];
        up_new = up_cur;
        case ({up_p1_ok, up_p0_ok})
            2'b10:   up_new = (up_cur == CNT_MAX) ? up_cur : up_cur + CNT_W'(1);
            2'b01:   up_new = (up_cur == '0)      ? up_cur : up_cur - CNT_W'(1);
            default: up_new = up_cur;
        endcase
    end

    // Next-state, write port and read-port control
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        wr_en      = 1'b0;
        wr_addr    = up_addr;
        wr_data    = up_new;
        rd_fire    = 1'b0;
        rd_data    = '0;

        case (state)
            ST_INIT: begin
                wr_en    = 1'b1;
                wr_addr  = ptr;
                wr_data  = CNT_INIT;
                ptr_next = ptr + ADDR_W'(1);
                if (ptr == LAST_IDX) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                wr_en   = up_en;
                rd_fire = rd_en;
            end
            default: begin
                state_next = ST_INIT;
                ptr_next   = '0;
            end
        endcase

        // Restart request discards this cycle's write; the sweep rewrites everything
        if (init_req) begin
            state_next = ST_INIT;
            ptr_next   = '0;
            wr_en      = 1'b0;
        end

        rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            ptr      <= '0;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_cnt   <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            busy     <= (state_next == ST_INIT);
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_cnt <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_sel = rd_cnt[CNT_W-1];

endmodule
